// File: rtl/br_arb_pri_age_pkg.sv
// Shared definitions for the priority-aging stage in front of br_arb_pri_rr.
// Optional integration assertions: define BR_ARB_PRI_AGE_CHECKS_EN.
package br_arb_pri_age_pkg;

    localparam int MinRequesters   = 2;
    localparam int MinPriorities   = 2;
    localparam int MinAgeThreshold = 2;

    typedef enum logic [2:0] {
        AgeClear,
        AgeCount,
        AgeBoost,
        AgeStarve,
        AgeHold
    } age_action_e;

    // Priority as the arbiter sees it: anything past the top level collapses onto it.
    function automatic int unsigned clampPriority(input int unsigned pri,
                                                  input int unsigned numPriorities);
        return (pri >= numPriorities) ? (numPriorities - 1) : pri;
    endfunction

endpackage

// File: rtl/br_arb_pri_age_slice.sv
// One requester's aging state: wait counter, boost level, starved flag and the
// saturating effective-priority computation.
module br_arb_pri_age_slice
    import br_arb_pri_age_pkg::*;
#(
    parameter int NumPriorities = 4,
    parameter int AgeThreshold  = 8,
    localparam int PriorityWidth = $clog2(NumPriorities)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     age_enable,
    input  logic                     in_request,
    input  logic [PriorityWidth-1:0] in_priority,
    input  logic                     grant,
    output logic [PriorityWidth-1:0] out_priority,
    output logic                     starved
);

    localparam int CntWidth = $clog2(AgeThreshold);
    localparam int SumWidth = PriorityWidth + 1;
    localparam logic [CntWidth-1:0]      LastCount = CntWidth'(AgeThreshold - 1);
    localparam logic [PriorityWidth-1:0] MaxPri    = PriorityWidth'(NumPriorities - 1);
    localparam logic [SumWidth-1:0]      MaxSum    = SumWidth'(NumPriorities - 1);

    logic [CntWidth-1:0]      r_wcnt;
    logic [PriorityWidth-1:0] r_boost;
    logic                     r_starved;

    logic [SumWidth-1:0]      w_sum;
    logic [PriorityWidth-1:0] w_effPri;
    logic                     w_waiting;
    age_action_e              w_action;

    // The extra sum bit keeps base+boost from wrapping before the clamp.
    always_comb begin
        w_sum    = {1'b0, in_priority} + {1'b0, r_boost};
        w_effPri = w_sum[PriorityWidth-1:0];
        if (w_sum > MaxSum) begin
            w_effPri = MaxPri;
        end
    end

    always_comb begin
        w_waiting = in_request & ~grant & age_enable;
        w_action  = AgeHold;
        if (!in_request || grant) begin
            w_action = AgeClear;
        end else if (w_waiting) begin
            if (r_wcnt == LastCount) begin
                w_action = (w_effPri < MaxPri) ? AgeBoost : AgeStarve;
            end else begin
                w_action = AgeCount;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt    <= '0;
            r_boost   <= '0;
            r_starved <= 1'b0;
        end else begin
            case (w_action)
                AgeClear: begin
                    r_wcnt    <= '0;
                    r_boost   <= '0;
                    r_starved <= 1'b0;
                end
                AgeCount: begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
                AgeBoost: begin
                    r_wcnt  <= '0;
                    r_boost <= r_boost + 1'b1;
                end
                AgeStarve: begin
                    r_wcnt    <= '0;
                    r_starved <= 1'b1;
                end
                default: begin
                    r_wcnt    <= r_wcnt;
                    r_boost   <= r_boost;
                    r_starved <= r_starved;
                end
            endcase
        end
    end

    assign out_priority = w_effPri;
    assign starved      = r_starved;

endmodule

// File: rtl/br_arb_pri_age.sv
// Priority-aging stage feeding br_arb_pri_rr: boosts requesters that wait too long.
// Optional integration assertions: define BR_ARB_PRI_AGE_CHECKS_EN.
module br_arb_pri_age
    import br_arb_pri_age_pkg::*;
#(
    parameter int NumRequesters = 2,
    parameter int NumPriorities = 4,
    parameter int AgeThreshold  = 8,
    localparam int PriorityWidth = $clog2(NumPriorities)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   age_enable,
    input  logic [NumRequesters-1:0]               in_request,
    input  logic [NumRequesters*PriorityWidth-1:0] in_priority,
    input  logic [NumRequesters-1:0]               grant,
    output logic [NumRequesters-1:0]               out_request,
    output logic [NumRequesters*PriorityWidth-1:0] out_priority,
    output logic [NumRequesters-1:0]               starved
);

    if (NumRequesters < MinRequesters) begin : g_badRequesters
        $error("br_arb_pri_age: NumRequesters must be at least 2");
    end
    if (NumPriorities < MinPriorities) begin : g_badPriorities
        $error("br_arb_pri_age: NumPriorities must be at least 2");
    end
    if (AgeThreshold < MinAgeThreshold) begin : g_badThreshold
        $error("br_arb_pri_age: AgeThreshold must be at least 2");
    end

    assign out_request = in_request;

    for (genvar i = 0; i < NumRequesters; i++) begin : g_slice
        br_arb_pri_age_slice #(
            .NumPriorities(NumPriorities),
            .AgeThreshold (AgeThreshold)
        ) u_slice (
            .clk         (clk),
            .rst_n       (rst_n),
            .age_enable  (age_enable),
            .in_request  (in_request[i]),
            .in_priority (in_priority[i*PriorityWidth +: PriorityWidth]),
            .grant       (grant[i]),
            .out_priority(out_priority[i*PriorityWidth +: PriorityWidth]),
            .starved     (starved[i])
        );
    end

`ifdef BR_ARB_PRI_AGE_CHECKS_EN
    a_grantOnehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));

    a_grantSubset : assert property (@(posedge clk) disable iff (!rst_n)
        (grant & ~out_request) == '0);

    for (genvar i = 0; i < NumRequesters; i++) begin : g_checks
        a_priInRange : assert property (@(posedge clk) disable iff (!rst_n)
            !out_request[i] ||
            (int'(out_priority[i*PriorityWidth +: PriorityWidth]) < NumPriorities));

        // A grant wipes the boost, so the arbiter must see the plain base level next.
        a_grantDropsBoost : assert property (@(posedge clk) disable iff (!rst_n)
            grant[i] |=> (!in_request[i] ||
                (int'(out_priority[i*PriorityWidth +: PriorityWidth]) ==
                 int'(clampPriority(int'(in_priority[i*PriorityWidth +: PriorityWidth]),
                                    NumPriorities)))));
    end
`else
    // Integration assertions are compiled out; datapath is unchanged.
`endif

endmodule

// File: tb/tb_br_arb_pri_age.sv
// Directed table-driven bench for br_arb_pri_age (4 requesters, 4 levels, threshold 3).
module tb_br_arb_pri_age;

    logic       clk;
    logic       rst_n;
    logic       age_enable;
    logic [3:0] in_request;
    logic [7:0] in_priority;
    logic [3:0] grant;
    logic [3:0] out_request;
    logic [7:0] out_priority;
    logic [3:0] starved;

    int checkCount;
    int errorCount;

    typedef struct {
        string      name;
        logic       ageEn;
        logic [3:0] req;
        logic [7:0] pri;
        logic [3:0] gnt;
        logic [7:0] expPri;
        logic [3:0] expStarved;
    } vector_t;

    vector_t vecs[$];

    br_arb_pri_age #(
        .NumRequesters(4),
        .NumPriorities(4),
        .AgeThreshold (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .age_enable  (age_enable),
        .in_request  (in_request),
        .in_priority (in_priority),
        .grant       (grant),
        .out_request (out_request),
        .out_priority(out_priority),
        .starved     (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input string name, input logic en, input logic [3:0] req,
                          input logic [7:0] pri, input logic [3:0] gnt,
                          input logic [7:0] expPri, input logic [3:0] expSt);
        vector_t v;
        v.name       = name;
        v.ageEn      = en;
        v.req        = req;
        v.pri        = pri;
        v.gnt        = gnt;
        v.expPri     = expPri;
        v.expStarved = expSt;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] req,
                                 input logic [7:0] pri, input logic [3:0] gnt);
        age_enable  = en;
        in_request  = req;
        in_priority = pri;
        grant       = gnt;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expReq,
                               input logic [7:0] expPri, input logic [3:0] expSt);
        checkCount++;
        if (out_request !== expReq) begin
            errorCount++;
            $display("[TB] FAIL %s out_request: got %b expected %b", name, out_request, expReq);
        end
        checkCount++;
        if (out_priority !== expPri) begin
            errorCount++;
            $display("[TB] FAIL %s out_priority: got %h expected %h", name, out_priority, expPri);
        end
        checkCount++;
        if (starved !== expSt) begin
            errorCount++;
            $display("[TB] FAIL %s starved: got %b expected %b", name, starved, expSt);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;

        // Req0 at base 0, never granted: one level every 3 cycles, starved at the top.
        addVec("A01", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("A02", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("A03", 1, 4'b0001, 8'h00, 4'b0000, 8'h01, 4'b0000);
        addVec("A04", 1, 4'b0001, 8'h00, 4'b0000, 8'h01, 4'b0000);
        addVec("A05", 1, 4'b0001, 8'h00, 4'b0000, 8'h01, 4'b0000);
        addVec("A06", 1, 4'b0001, 8'h00, 4'b0000, 8'h02, 4'b0000);
        addVec("A07", 1, 4'b0001, 8'h00, 4'b0000, 8'h02, 4'b0000);
        addVec("A08", 1, 4'b0001, 8'h00, 4'b0000, 8'h02, 4'b0000);
        addVec("A09", 1, 4'b0001, 8'h00, 4'b0000, 8'h03, 4'b0000);
        addVec("A10", 1, 4'b0001, 8'h00, 4'b0000, 8'h03, 4'b0000);
        addVec("A11", 1, 4'b0001, 8'h00, 4'b0000, 8'h03, 4'b0000);
        addVec("A12", 1, 4'b0001, 8'h00, 4'b0000, 8'h03, 4'b0001);
        addVec("A13", 1, 4'b0001, 8'h00, 4'b0000, 8'h03, 4'b0001);
        addVec("A14gnt", 1, 4'b0001, 8'h00, 4'b0001, 8'h00, 4'b0000);
        // Fresh aging with a grant in cycle 5, then restart from zero.
        addVec("B01", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("B02", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("B03", 1, 4'b0001, 8'h00, 4'b0000, 8'h01, 4'b0000);
        addVec("B04", 1, 4'b0001, 8'h00, 4'b0000, 8'h01, 4'b0000);
        addVec("B05gnt", 1, 4'b0001, 8'h00, 4'b0001, 8'h00, 4'b0000);
        addVec("B06", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("B07", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("B08", 1, 4'b0001, 8'h00, 4'b0000, 8'h01, 4'b0000);
        // Grant coinciding with the threshold cycle must not boost.
        addVec("C00gnt", 1, 4'b0001, 8'h00, 4'b0001, 8'h00, 4'b0000);
        addVec("C01", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("C02", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("C03gntThr", 1, 4'b0001, 8'h00, 4'b0001, 8'h00, 4'b0000);
        addVec("C04", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("C05", 1, 4'b0001, 8'h00, 4'b0000, 8'h00, 4'b0000);
        addVec("C06", 1, 4'b0001, 8'h00, 4'b0000, 8'h01, 4'b0000);
        addVec("Cdrop", 1, 4'b0000, 8'h00, 4'b0000, 8'h00, 4'b0000);
        // Req1 (base 1) waits while req2 (base 3) is granted every cycle; aging paused.
        addVec("D01", 1, 4'b0110, 8'h34, 4'b0100, 8'h34, 4'b0000);
        addVec("D02", 1, 4'b0110, 8'h34, 4'b0100, 8'h34, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            addVec($sformatf("Dhold%0d", k), 0, 4'b0110, 8'h34, 4'b0100, 8'h34, 4'b0000);
        end
        addVec("Dresume", 1, 4'b0110, 8'h34, 4'b0100, 8'h38, 4'b0000);
        // Req1 base raised to 2 keeping boost 1, then one more threshold starves it.
        addVec("E01", 1, 4'b0110, 8'h38, 4'b0100, 8'h3C, 4'b0000);
        addVec("E02", 1, 4'b0110, 8'h38, 4'b0100, 8'h3C, 4'b0000);
        addVec("E03", 1, 4'b0110, 8'h38, 4'b0100, 8'h3C, 4'b0010);
        addVec("E04", 1, 4'b0110, 8'h38, 4'b0100, 8'h3C, 4'b0010);

        rst_n = 1'b0;
        applyStimulus(1'b1, 4'b1111, 8'h55, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset", 4'b1111, 8'h55, 4'b0000);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ageEn, vecs[i].req, vecs[i].pri, vecs[i].gnt);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, vecs[i].req, vecs[i].expPri, vecs[i].expStarved);
        end

        // Base 3 plus boost 1 would wrap to 0 without the clamp.
        applyStimulus(1'b1, 4'b0110, 8'h3C, 4'b0100);
        #1;
        checkOutput("H_clampWrap", 4'b0110, 8'h3C, 4'b0010);

        // Asynchronous reset mid-cycle drops the boost before any edge.
        applyStimulus(1'b1, 4'b0110, 8'h38, 4'b0100);
        #1;
        checkOutput("H_preReset", 4'b0110, 8'h3C, 4'b0010);
        rst_n = 1'b0;
        #1;
        checkOutput("H_asyncReset", 4'b0110, 8'h38, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("H_reage%0d", k), 4'b0110,
                        (k == 3) ? 8'h3C : 8'h38, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
